usb_rx_pkt_ctrl: RTL and testbench

- Receive-side packet controller for the USB device core. It consumes de-stuffed bytes from the byte assembler and decodes and validates the PID.
- For DATA packets it streams every post-PID byte to the CRC16 residual checker and writes payload bytes into the RX FIFO. The two trailing CRC bytes are held back in a 2-byte delay buffer so they never reach the FIFO.
- At EOP it reports packet status to the protocol FSM.

---
 rtl/usb_pkg.sv | 34 +++
 rtl/usb_rx_hold2.sv | 46 ++++
 rtl/usb_rx_pkt_ctrl.sv | 157 +++++++++++++++
 tb/tb_usb_rx_pkt_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB receive-path types: PID constants, packet error codes and
// the receive packet controller state encoding.
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        PID_ERR  = 3'd1,
        SHORT    = 3'd2,
        CRC_ERR  = 3'd3,
        OVERFLOW = 3'd4,
        OVERRUN  = 3'd5,
        RX_ERR   = 3'd6
    } rx_err_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        SKIP  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } rx_state_t;

    function automatic logic is_data_pid(input logic [3:0] p);
        return (p == PID_DATA0) || (p == PID_DATA1) ||
               (p == PID_DATA2) || (p == PID_MDATA);
    endfunction

endpackage

// File: rtl/usb_rx_hold2.sv
// Two-byte delay line that keeps the trailing CRC16 bytes of a DATA packet
// away from the FIFO; out_byte is the oldest held byte once two are held.
module usb_rx_hold2 (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic [1:0] count
);

    logic [7:0] b0;
    logic [7:0] b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            b0    <= 8'h00;
            b1    <= 8'h00;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push) begin
            case (count)
                2'd0: begin
                    b0    <= in_byte;
                    count <= 2'd1;
                end
                2'd1: begin
                    b1    <= in_byte;
                    count <= 2'd2;
                end
                default: begin
                    // Full: the oldest byte leaves through out_byte this cycle.
                    b0 <= b1;
                    b1 <= in_byte;
                end
            endcase
        end
    end

    assign out_valid = (count == 2'd2);
    assign out_byte  = b0;

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Receive packet controller: PID decode/check, CRC16 byte feed, payload
// streaming to the RX FIFO with CRC bytes held back, and end-of-packet status.
module usb_rx_pkt_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1023,
    parameter int LEN_W       = 11
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             eop,
    input  logic             rx_error,
    output logic             crc_clr,
    output logic             crc_en,
    output logic [7:0]       crc_data,
    input  logic             crc_ok,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [7:0]       fifo_wdata,
    output logic             pkt_done,
    output logic             pkt_good,
    output logic [2:0]       err_code,
    output logic [3:0]       pid,
    output logic [LEN_W-1:0] payload_len,
    output rx_state_t        dbg_state
);

    // Flow control: byte_valid, eop and rx_error are single-cycle strobes with
    // no back-pressure toward the bit layer; fifo_full is the only ready-style
    // signal and a write presented while it is high is discarded, never retried.

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_PAYLOAD);

    rx_state_t        state;
    rx_err_t          err;
    logic             is_data;
    logic [LEN_W-1:0] byte_cnt;

    logic       hold_push;
    logic       hold_flush;
    logic       hold_full;
    logic [7:0] hold_byte;
    logic [1:0] hold_count;

    assign hold_push  = (state == DATA) && byte_valid && !rx_error && !eop &&
                        (err == NONE);
    assign hold_flush = (state == DONE);

    usb_rx_hold2 u_hold (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (hold_push),
        .flush     (hold_flush),
        .in_byte   (byte_data),
        .out_valid (hold_full),
        .out_byte  (hold_byte),
        .count     (hold_count)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            err         <= NONE;
            is_data     <= 1'b0;
            byte_cnt    <= '0;
            crc_clr     <= 1'b0;
            crc_en      <= 1'b0;
            crc_data    <= 8'h00;
            fifo_wr     <= 1'b0;
            fifo_wdata  <= 8'h00;
            pkt_done    <= 1'b0;
            pkt_good    <= 1'b0;
            err_code    <= 3'd0;
            pid         <= 4'h0;
            payload_len <= '0;
        end else begin
            crc_clr  <= 1'b0;
            crc_en   <= 1'b0;
            fifo_wr  <= 1'b0;
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        crc_clr  <= 1'b1;
                        pid      <= byte_data[3:0];
                        err      <= NONE;
                        byte_cnt <= '0;
                        is_data  <= 1'b0;
                        if (byte_data[3:0] != ~byte_data[7:4]) begin
                            err   <= PID_ERR;
                            state <= SKIP;
                        end else if (is_data_pid(byte_data[3:0])) begin
                            is_data <= 1'b1;
                            state   <= DATA;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                DATA: begin
                    if (rx_error && err == NONE) begin
                        err <= RX_ERR;
                    end else if (eop) begin
                        if (err == NONE && hold_count != 2'd2)
                            err <= SHORT;
                    end else if (byte_valid && err == NONE) begin
                        crc_en   <= 1'b1;
                        crc_data <= byte_data;
                        if (hold_full) begin
                            if (byte_cnt >= MAX_CNT) begin
                                err <= OVERFLOW;
                            end else if (fifo_full) begin
                                err <= OVERRUN;
                            end else begin
                                fifo_wr    <= 1'b1;
                                fifo_wdata <= hold_byte;
                                byte_cnt   <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    if (eop)
                        state <= CHECK;
                end
                SKIP: begin
                    if (rx_error && err == NONE)
                        err <= RX_ERR;
                    if (eop)
                        state <= CHECK;
                end
                CHECK: begin
                    // The residual has settled by now: the last byte left the
                    // controller at least two cycles ago.
                    if (rx_error && err == NONE)
                        err <= RX_ERR;
                    else if (is_data && err == NONE && !crc_ok)
                        err <= CRC_ERR;
                    state <= DONE;
                end
                DONE: begin
                    pkt_done    <= 1'b1;
                    pkt_good    <= (err == NONE);
                    err_code    <= err;
                    payload_len <= is_data ? byte_cnt : '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed plus randomized packet bench for usb_rx_pkt_ctrl with a packet-level
// reference model and a scoreboard of expected CRC and FIFO byte streams.
module tb_usb_rx_pkt_ctrl;
    import usb_pkg::*;

    localparam int MAX = 1023;
    localparam int LW  = 11;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          eop;
    logic          rx_error;
    logic          crc_clr;
    logic          crc_en;
    logic [7:0]    crc_data;
    logic          crc_ok;
    logic          fifo_full;
    logic          fifo_wr;
    logic [7:0]    fifo_wdata;
    logic          pkt_done;
    logic          pkt_good;
    logic [2:0]    err_code;
    logic [3:0]    pid;
    logic [LW-1:0] payload_len;
    rx_state_t     dbg_state;

    usb_rx_pkt_ctrl #(.MAX_PAYLOAD(MAX), .LEN_W(LW)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .eop         (eop),
        .rx_error    (rx_error),
        .crc_clr     (crc_clr),
        .crc_en      (crc_en),
        .crc_data    (crc_data),
        .crc_ok      (crc_ok),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_wdata  (fifo_wdata),
        .pkt_done    (pkt_done),
        .pkt_good    (pkt_good),
        .err_code    (err_code),
        .pid         (pid),
        .payload_len (payload_len),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] pkt_q[$];
    logic [7:0] exp_crc_q[$];
    logic [7:0] exp_fifo_q[$];
    logic [7:0] got_crc_q[$];
    logic [7:0] got_fifo_q[$];
    int         done_cnt;
    int         clr_cnt;

    int exp_err;
    int exp_len;
    int exp_pid;

    // output monitor
    always @(negedge clk) begin
        if (crc_en)   got_crc_q.push_back(crc_data);
        if (fifo_wr)  got_fifo_q.push_back(fifo_wdata);
        if (pkt_done) done_cnt++;
        if (crc_clr)  clr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_is_data(input logic [3:0] p);
        return p == 4'h3 || p == 4'hB || p == 4'h7 || p == 4'hF;
    endfunction

    // Packet-level reference: walks post-PID byte positions, tracking the
    // first error and which bytes must reach the checker and the FIFO.
    task automatic model_pkt(input bit ok, input int full_at, input int rx_at);
        int  npost;
        int  nw;
        bit  bad;
        bit  dat;
        exp_crc_q.delete();
        exp_fifo_q.delete();
        exp_pid = int'(pkt_q[0][3:0]);
        bad     = (pkt_q[0][7:4] != ~pkt_q[0][3:0]);
        dat     = !bad && tb_is_data(pkt_q[0][3:0]);
        exp_err = bad ? 1 : 0;
        npost   = pkt_q.size() - 1;
        nw      = 0;
        for (int k = 0; k <= npost; k++) begin
            if (k == rx_at && exp_err == 0) exp_err = 6;
            if (k == npost) break;
            if (dat && exp_err == 0) begin
                exp_crc_q.push_back(pkt_q[k+1]);
                if (k >= 2) begin
                    if (nw == MAX)          exp_err = 4;
                    else if (k == full_at)  exp_err = 5;
                    else begin
                        exp_fifo_q.push_back(pkt_q[k-1]);
                        nw++;
                    end
                end
            end
        end
        if (dat && exp_err == 0 && npost < 2) exp_err = 2;
        if (dat && exp_err == 0 && !ok)       exp_err = 3;
        exp_len = dat ? nw : 0;
    endtask

    // driver
    task automatic send_pkt(input bit ok, input int full_at, input int rx_at, input int max_gap);
        int npost;
        int waited;
        npost = pkt_q.size() - 1;
        crc_ok = ok;
        got_crc_q.delete();
        got_fifo_q.delete();
        done_cnt = 0;
        clr_cnt  = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = pkt_q[0];
        @(negedge clk);
        byte_valid = 1'b0;
        for (int k = 0; k <= npost; k++) begin
            if (k == rx_at) begin
                rx_error = 1'b1;
                @(negedge clk);
                rx_error = 1'b0;
            end
            if (k == npost) break;
            repeat (int'($urandom_range(0, max_gap))) @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = pkt_q[k+1];
            fifo_full  = (k == full_at);
            @(negedge clk);
            byte_valid = 1'b0;
            fifo_full  = 1'b0;
        end
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        waited = 0;
        while (done_cnt == 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
    endtask

    // scoreboard
    task automatic run_pkt(input string name, input bit ok, input int full_at,
                           input int rx_at, input int max_gap);
        int n;
        model_pkt(ok, full_at, rx_at);
        send_pkt(ok, full_at, rx_at, max_gap);
        chk({name, ".pkt_done_count"}, 32'(done_cnt), 32'd1);
        chk({name, ".crc_clr_count"}, 32'(clr_cnt), 32'd1);
        chk({name, ".crc_en_count"}, 32'(got_crc_q.size()), 32'(exp_crc_q.size()));
        n = (got_crc_q.size() < exp_crc_q.size()) ? got_crc_q.size() : exp_crc_q.size();
        for (int i = 0; i < n; i++)
            chk({name, ".crc_data"}, 32'(got_crc_q[i]), 32'(exp_crc_q[i]));
        chk({name, ".fifo_wr_count"}, 32'(got_fifo_q.size()), 32'(exp_fifo_q.size()));
        n = (got_fifo_q.size() < exp_fifo_q.size()) ? got_fifo_q.size() : exp_fifo_q.size();
        for (int i = 0; i < n; i++)
            chk({name, ".fifo_wdata"}, 32'(got_fifo_q[i]), 32'(exp_fifo_q[i]));
        chk({name, ".err_code"}, 32'(err_code), 32'(exp_err));
        chk({name, ".pkt_good"}, 32'(pkt_good), 32'(exp_err == 0));
        chk({name, ".pid"}, 32'(pid), 32'(exp_pid));
        chk({name, ".payload_len"}, 32'(payload_len), 32'(exp_len));
        chk({name, ".state_idle"}, 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, ".crc_clr"}, 32'(crc_clr), 32'd0);
        chk({name, ".crc_en"}, 32'(crc_en), 32'd0);
        chk({name, ".crc_data"}, 32'(crc_data), 32'd0);
        chk({name, ".fifo_wr"}, 32'(fifo_wr), 32'd0);
        chk({name, ".fifo_wdata"}, 32'(fifo_wdata), 32'd0);
        chk({name, ".pkt_done"}, 32'(pkt_done), 32'd0);
        chk({name, ".pkt_good"}, 32'(pkt_good), 32'd0);
        chk({name, ".err_code"}, 32'(err_code), 32'd0);
        chk({name, ".pid"}, 32'(pid), 32'd0);
        chk({name, ".payload_len"}, 32'(payload_len), 32'd0);
        chk({name, ".state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        logic [3:0] p;
        logic [3:0] hi;
        int         kind;
        int         len;
        int         f_at;
        int         r_at;

        n_rst      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        eop        = 1'b0;
        rx_error   = 1'b0;
        crc_ok     = 1'b1;
        fifo_full  = 1'b0;
        done_cnt   = 0;
        clr_cnt    = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // eop and rx_error while idle do nothing
        done_cnt = 0;
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_eop.pkt_done_count", 32'(done_cnt), 32'd0);

        pkt_q = '{8'hC3, 8'h00, 8'h00};
        run_pkt("zero_len_data0", 1'b1, -1, -1, 1);
        chk("zero_len_data0.direct_len", 32'(payload_len), 32'd0);

        pkt_q = '{8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC0, 8'hC1};
        run_pkt("data1_good", 1'b1, -1, -1, 2);
        chk("data1_good.direct_len", 32'(payload_len), 32'd4);

        pkt_q = '{8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC0, 8'hC1};
        run_pkt("data1_crc_bad", 1'b0, -1, -1, 2);
        chk("data1_crc_bad.direct_err", 32'(err_code), 32'd3);

        pkt_q = '{8'hC4, 8'h11, 8'h22};
        run_pkt("bad_pid", 1'b1, -1, -1, 1);
        chk("bad_pid.direct_err", 32'(err_code), 32'd1);

        pkt_q = '{8'hD2};
        run_pkt("ack", 1'b1, -1, -1, 0);

        pkt_q = '{8'hC3, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        run_pkt("overrun", 1'b1, 3, 5, 1);
        chk("overrun.direct_err", 32'(err_code), 32'd5);

        pkt_q = '{8'h4B, 8'h55};
        run_pkt("short", 1'b1, -1, -1, 1);

        pkt_q = '{8'hC3, 8'h10, 8'h20, 8'h30};
        run_pkt("rx_err_data", 1'b1, -1, 2, 1);

        // longest legal payload plus extra bytes: must report OVERFLOW
        pkt_q = '{8'h87};
        for (int i = 0; i < MAX + 5; i++) pkt_q.push_back(8'($urandom));
        run_pkt("overflow", 1'b1, -1, -1, 0);
        chk("overflow.direct_len", 32'(payload_len), 32'(MAX));

        // exactly MAX payload bytes is still good
        pkt_q = '{8'h0F};
        for (int i = 0; i < MAX + 2; i++) pkt_q.push_back(8'($urandom));
        run_pkt("max_payload", 1'b1, -1, -1, 0);

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            pkt_q.delete();
            if (kind <= 1) begin
                case ($urandom_range(0, 3))
                    0:       p = 4'h3;
                    1:       p = 4'hB;
                    2:       p = 4'h7;
                    default: p = 4'hF;
                endcase
                len = int'($urandom_range(0, 10));
            end else if (kind == 2) begin
                p = 4'(($urandom));
                while (tb_is_data(p)) p = 4'($urandom);
                len = int'($urandom_range(0, 3));
            end else begin
                p   = 4'($urandom);
                len = int'($urandom_range(0, 4));
            end
            hi = ~p;
            if (kind == 3) hi = hi ^ 4'($urandom_range(1, 15));
            pkt_q.push_back({hi, p});
            for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
            f_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len));
            r_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            run_pkt("random", 1'($urandom), f_at, r_at, 2);
        end

        // asynchronous reset in the middle of a DATA packet
        done_cnt = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            byte_data = 8'(i + 8'h40);
        end
        byte_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_reset.pkt_done_count", 32'(done_cnt), 32'd0);

        pkt_q = '{8'h4B, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        run_pkt("after_reset", 1'b1, -1, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
